// File: rtl/stopwatch.sv
// Stopwatch: counts elapsed beats of BEAT_PERIOD clocks between start and stop.
// A result handshake holds the stopped value until the consumer acknowledges it.
// Optional lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch #(
  parameter int BEAT_PERIOD = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  input  logic       result_ack,
  output logic [7:0] elapsed,
  output logic       running,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       overflow,
  output logic [7:0] lap_val
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    STOPPED = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(BEAT_PERIOD - 1);

  state_t     state, state_nxt;
  logic [7:0] div;
  logic       go, halt, tick, in_run;
  logic [7:0] elapsed_nxt;
  logic       sat_hit;

  assign in_run = (state == RUNNING);
  assign tick   = in_run && (div == DIV_LAST);

  // Elapsed value as it stands after this cycle's tick; stop and lap capture this.
  assign sat_hit     = tick && (elapsed == 8'hFF);
  assign elapsed_nxt = (tick && !sat_hit) ? elapsed + 8'd1 : elapsed;

  // Next-state decode: clear beats stop, stop only in RUNNING, start only when not RUNNING.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    halt      = 1'b0;
    case (state)
      IDLE, STOPPED: if (start) begin
        state_nxt = RUNNING;
        go        = 1'b1;
      end
      RUNNING: if (stop) begin
        state_nxt = STOPPED;
        halt      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) begin
      state_nxt = IDLE;
      go        = 1'b0;
      halt      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Running flag registered from next state so it tracks the state register exactly.
  always_ff @(posedge clk) begin
    if (rst) running <= 1'b0;
    else     running <= (state_nxt == RUNNING);
  end

  // Beat divider: free-runs only while RUNNING, parked at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst || clear || go || halt || !in_run) div <= 8'd0;
    else if (tick)                             div <= 8'd0;
    else                                       div <= div + 8'd1;
  end

  // Elapsed count and sticky saturation flag for the current measurement.
  always_ff @(posedge clk) begin
    if (rst || clear || go) begin
      elapsed  <= 8'd0;
      overflow <= 1'b0;
    end else if (in_run) begin
      elapsed  <= elapsed_nxt;
      overflow <= overflow | sat_hit;
    end
  end

  // Result capture; a stop wins over an acknowledge in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      result       <= 8'd0;
      result_valid <= 1'b0;
    end else if (halt) begin
      result       <= elapsed_nxt;
      result_valid <= 1'b1;
    end else if (result_ack && result_valid) begin
      result_valid <= 1'b0;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Lap capture of the live count while RUNNING; does not disturb the measurement.
  always_ff @(posedge clk) begin
    if (rst || clear)        lap_val <= 8'd0;
    else if (in_run && lap)  lap_val <= elapsed_nxt;
  end
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_val    = 8'd0;
`endif

endmodule

// File: tb/tb_stopwatch.sv
// Bench for stopwatch at BEAT_PERIOD=4: directed table plus randomized run
// against a cycle-count reference model. Honors STOPWATCH_LAP_EN.
module tb_stopwatch;

  localparam int P = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif
  localparam int L4 = LAP_EN ? 4 : 0;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear, lap, result_ack;
  logic [7:0] elapsed, result, lap_val;
  logic       running, result_valid, overflow;

  int errors = 0;
  int checks = 0;

  stopwatch #(.BEAT_PERIOD(P)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .result_ack(result_ack), .elapsed(elapsed), .running(running), .result(result),
    .result_valid(result_valid), .overflow(overflow), .lap_val(lap_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r, s, p, c, l, a;
    int n;
    int el, run, res, rv, ov, lv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit s, bit p, bit c, bit l, bit a, int n,
                              int el, int run, int res, int rv, int ov, int lv);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.c = c; v.l = l; v.a = a; v.n = n;
    v.el = el; v.run = run; v.res = res; v.rv = rv; v.ov = ov; v.lv = lv;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int el, input int run, input int res,
                         input int rv, input int ov, input int lv);
    chk({tag, " elapsed"},      int'(elapsed),      el);
    chk({tag, " running"},      int'(running),      run);
    chk({tag, " result"},       int'(result),       res);
    chk({tag, " result_valid"}, int'(result_valid), rv);
    chk({tag, " overflow"},     int'(overflow),     ov);
    chk({tag, " lap_val"},      int'(lap_val),      lv);
  endtask

  task automatic drive(input bit r, input bit s, input bit p, input bit c, input bit l, input bit a);
    rst = r; start = s; stop = p; clear = c; lap = l; result_ack = a;
  endtask

  // Reference model: measurement is the number of RUNNING cycles since start;
  // elapsed beats are that count divided by the beat period, capped at 255.
  typedef enum int {M_IDLE, M_RUN, M_STOP} mstate_t;
  mstate_t m_st;
  int m_cyc, m_res, m_rv, m_lap;

  function automatic int beats(int cyc);
    return (cyc / P > 255) ? 255 : cyc / P;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit p, input bit c, input bit l, input bit a);
    if (r || c) begin
      m_st = M_IDLE; m_cyc = 0; m_res = 0; m_rv = 0; m_lap = 0;
    end else if (m_st == M_RUN) begin
      m_cyc++;
      if (l && LAP_EN) m_lap = beats(m_cyc);
      if (p) begin
        m_st = M_STOP; m_res = beats(m_cyc); m_rv = 1;
      end else if (a && m_rv == 1) m_rv = 0;
    end else begin
      if (a && m_rv == 1) m_rv = 0;
      if (s) begin m_st = M_RUN; m_cyc = 0; end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);

    //        r s p c l a  n     el  run res rv ov lv
    tbl.push_back(mk(1,0,0,0,0,0, 2,    0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 1,    0,  1,  0, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 12,   3,  1,  0, 0, 0, 0));
    tbl.push_back(mk(0,0,1,0,0,0, 1,    3,  0,  3, 1, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 10,   3,  0,  3, 1, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,1, 1,    3,  0,  3, 0, 0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 1,    0,  1,  3, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 16,   4,  1,  3, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 1,    4,  1,  3, 0, 0, L4));
    tbl.push_back(mk(0,0,0,0,0,0, 6,    5,  1,  3, 0, 0, L4));
    tbl.push_back(mk(0,0,1,0,0,0, 1,    6,  0,  6, 1, 0, L4));
    tbl.push_back(mk(0,1,0,0,0,0, 1,    0,  1,  6, 1, 0, L4));
    tbl.push_back(mk(0,0,0,0,0,0, 8,    2,  1,  6, 1, 0, L4));
    tbl.push_back(mk(0,0,1,0,0,1, 1,    2,  0,  2, 1, 0, L4));
    tbl.push_back(mk(0,1,0,0,0,0, 1,    0,  1,  2, 1, 0, L4));
    tbl.push_back(mk(0,0,0,0,0,0, 28,   7,  1,  2, 1, 0, L4));
    tbl.push_back(mk(0,0,0,1,0,0, 1,    0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0,1,1,0,0,0, 1,    0,  1,  0, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 28,   7,  1,  0, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,0,0, 1,    0,  0,  0, 0, 0, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 1,    0,  1,  0, 0, 0, 0));
    tbl.push_back(mk(0,0,0,0,0,0, 1100, 255,1,  0, 0, 1, 0));
    tbl.push_back(mk(0,0,1,0,0,0, 1,    255,0,255, 1, 1, 0));
    tbl.push_back(mk(0,1,0,0,0,0, 1,    0,  1,255, 1, 0, 0));
    tbl.push_back(mk(0,0,1,0,0,0, 1,    0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 1,    0,  0,  0, 1, 0, 0));
    tbl.push_back(mk(0,0,1,0,0,1, 1,    0,  0,  0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l, tbl[i].a);
      repeat (tbl[i].n) @(posedge clk);
      #1;
      drive(0, 0, 0, 0, 0, 0);
      chk_all($sformatf("row%0d", i), tbl[i].el, tbl[i].run, tbl[i].res,
              tbl[i].rv, tbl[i].ov, tbl[i].lv);
    end

    // Randomized run against the model, starting from a reset.
    drive(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bit r, s, p, c, l, a;
      r = ($urandom_range(0, 199) == 0);
      c = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 8);
      p = ($urandom_range(0, 99) < 4);
      l = ($urandom_range(0, 99) < 10);
      a = ($urandom_range(0, 99) < 15);
      drive(r, s, p, c, l, a);
      model_step(r, s, p, c, l, a);
      @(posedge clk); #1;
      chk_all($sformatf("rnd%0d", cyc), beats(m_cyc), int'(m_st == M_RUN), m_res, m_rv,
              int'(m_cyc / P > 255), m_lap);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch.md
STOPWATCH -- requirements
Module: stopwatch

Interface
REQ-001 SHALL have parameter BEAT_PERIOD, default 32, clk cycles per elapsed-time beat (legal 2..256).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin or restart measurement (level sampled each cycle).
REQ-005 SHALL have port stop  input  1  end measurement and capture result.
REQ-006 SHALL have port clear  input  1  synchronous soft clear back to IDLE.
REQ-007 SHALL have port lap  input  1  capture running value without stopping.
REQ-008 SHALL have port result_ack  input  1  consumer accepts result.
REQ-009 SHALL have port elapsed  output  8  live beat count.
REQ-010 SHALL have port running  output  1  high while in RUNNING.
REQ-011 SHALL have port result  output  8  captured beat count at stop.
REQ-012 SHALL have port result_valid  output  1  result held and not yet acknowledged.
REQ-013 SHALL have port overflow  output  1  sticky, elapsed saturated during current measurement.
REQ-014 SHALL have port lap_val  output  8  last lap capture.

Function
REQ-015 SHALL implement states IDLE=2'd0, RUNNING=2'd1, STOPPED=2'd2; 2'd3 SHALL transition to IDLE next cycle.
REQ-016 SHALL transition IDLE->RUNNING and STOPPED->RUNNING on start; RUNNING->STOPPED on stop; any state->IDLE on clear.
REQ-017 Priority per cycle SHALL be rst > clear > stop (RUNNING only) > start (IDLE/STOPPED only); start in RUNNING and stop outside RUNNING SHALL be ignored.
REQ-018 On accepted start SHALL load elapsed=0, overflow=0, beat divider=0; result/result_valid unaffected.
REQ-019 Beat divider SHALL count 0..BEAT_PERIOD-1 only in RUNNING, hold at 0 elsewhere; tick asserts in the cycle divider==BEAT_PERIOD-1, divider then wraps to 0.
REQ-020 First tick SHALL occur BEAT_PERIOD cycles after the start cycle; elapsed SHALL increment by 1 on the edge ending each tick cycle.
REQ-021 Elapsed SHALL saturate at 8'd255; a tick at 255 SHALL leave 255 and set overflow, which stays high until clear, start or rst.
REQ-022 Stop SHALL load result with the elapsed value including any tick in the same cycle (saturated), set result_valid=1, freeze elapsed.
REQ-023 result_valid SHALL stay high until a cycle with result_ack=1, then clear next edge; result_ack while result_valid=0 SHALL be ignored.
REQ-024 Stop and result_ack in the same cycle SHALL leave result_valid=1 with the new result; a stop while result_valid=1 SHALL overwrite result.
REQ-025 running SHALL equal (state==RUNNING), registered, no combinational path from inputs.
REQ-026 Clear SHALL set elapsed=0, overflow=0, result=0, result_valid=0, lap_val=0, divider=0.
REQ-027 All outputs SHALL be registered; input-to-output latency one clock.

Reset
REQ-028 rst=1 at a rising edge SHALL force state IDLE, divider 0, elapsed 0, result 0, result_valid 0, overflow 0, lap_val 0, running 0.
REQ-029 rst mid-measurement SHALL discard all progress; no result produced.
REQ-030 After rst deasserts, a start SHALL be honoured on the first following edge.

Configuration
REQ-031 Macro STOPWATCH_LAP_EN defined: lap in RUNNING loads lap_val with elapsed including same-cycle tick; lap outside RUNNING ignored; lap with stop loads both.
REQ-032 Macro STOPWATCH_LAP_EN undefined: lap ignored, lap_val constant 8'd0, no lap register synthesized.

Verification (BEAT_PERIOD=4)
REQ-033 rst; start 1 cycle; stop 13 cycles after start -> elapsed=3, result=3, result_valid=1, running=0.
REQ-034 result_valid=1, hold result_ack=0 10 cycles -> result stable; ack 1 cycle -> result_valid=0 next edge.
REQ-035 start, run 1100 cycles -> elapsed=255, overflow=1; stop -> result=255; start -> elapsed=0, overflow=0.
REQ-036 stop on a tick cycle with elapsed=5 -> result=6; stop and result_ack same cycle -> result_valid stays 1.
REQ-037 clear or rst while RUNNING at elapsed=7 -> IDLE, all outputs 0 next edge; start+stop same cycle in IDLE -> RUNNING.
REQ-038 STOPWATCH_LAP_EN defined: lap at elapsed=4 -> lap_val=4, running stays 1; undefined: lap_val=0.
